// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Hardwired control unit for the DataPath's register-register ALU instructions.
//   Steps fetch (PC -> MAR, memory read into MDR, MDR -> IR), decodes the opcode and
//   register fields, and sequences the operand/result transfers through Y, Z, HI and LO.
//
// Ports
//   Clock, Clear           rising-edge clock, asynchronous active-high reset
//   start                  begin one instruction (sampled only in IDLE)
//   ir[31:0]               IR contents: opcode[31:27] ra[26:23] rb[22:19] rc[18:15]
//   mem_ready              memory read data valid on Mdatain
//   alu_done               multi-cycle MUL/DIV result valid in Z
//   PCout..MDRout          bus drive strobes
//   PCin..Read             register load / control strobes
//   Rout, Rin              one-hot general register drive / load
//   alu_op[12:0]           one-hot ALU op {NOT,NEG,DIV,MUL,OR,AND,ROL,ROR,SHL,SHRA,SHR,SUB,ADD}
//   busy, done, fault      status; fault_code holds the last fault until the next start
//
// Handshakes: mem_ready is looked at only in T1 and alu_done only in T4 of MUL/DIV.
// A high level at a rising edge completes the wait; the input is ignored everywhere else.
// All outputs are decoded from registered state only.

module alu_op_sequencer #(
    parameter int NUM_REGS    = 16,
    parameter int MEM_TIMEOUT = 15,
    parameter int ALU_TIMEOUT = 40
) (
    input  logic                Clock,
    input  logic                Clear,
    input  logic                start,
    input  logic [31:0]         ir,
    input  logic                mem_ready,
    input  logic                alu_done,
    output logic                PCout,
    output logic                Zlowout,
    output logic                Zhighout,
    output logic                MDRout,
    output logic                PCin,
    output logic                MARin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                HIin,
    output logic                LOin,
    output logic                IncPC,
    output logic                Read,
    output logic [NUM_REGS-1:0] Rout,
    output logic [NUM_REGS-1:0] Rin,
    output logic [12:0]         alu_op,
    output logic                busy,
    output logic                done,
    output logic                fault,
    output logic [1:0]          fault_code
);

    localparam int CW = 16;
    localparam logic [4:0] NR5 = 5'(NUM_REGS);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_FAULT
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [12:0]    op_q;
    logic [3:0]     ra_q, rb_q, rc_q;
    logic [1:0]     fcode_d;

    logic [12:0]    dec_op;
    logic           dec_unary, dec_muldiv, dec_illegal;
    logic           muldiv_q, unary_q;
    logic           unused_ir;

    assign unused_ir = ^ir[14:0];

    function automatic logic [12:0] decode_op(input logic [4:0] opc);
        case (opc)
            5'b00011: decode_op = 13'h0001;  // add
            5'b00100: decode_op = 13'h0002;  // sub
            5'b01001: decode_op = 13'h0004;  // shr
            5'b01010: decode_op = 13'h0008;  // shra
            5'b01011: decode_op = 13'h0010;  // shl
            5'b00111: decode_op = 13'h0020;  // ror
            5'b01000: decode_op = 13'h0040;  // rol
            5'b00101: decode_op = 13'h0080;  // and
            5'b00110: decode_op = 13'h0100;  // or
            5'b01111: decode_op = 13'h0200;  // mul
            5'b10000: decode_op = 13'h0400;  // div
            5'b10001: decode_op = 13'h0800;  // neg
            5'b10010: decode_op = 13'h1000;  // not
            default:  decode_op = 13'h0000;
        endcase
    endfunction

    function automatic logic [NUM_REGS-1:0] one_hot(input logic [3:0] idx);
        one_hot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            one_hot[i] = (idx == i[3:0]);
        end
    endfunction

    // Decode of the word on ir, consumed only at the edge that leaves T2.
    // rc is only an operand for the binary ops, so only they can fault on it.
    always_comb begin
        dec_op      = decode_op(ir[31:27]);
        dec_unary   = dec_op[11] | dec_op[12];
        dec_muldiv  = dec_op[9] | dec_op[10];
        dec_illegal = (dec_op == 13'h0000)
                    || ({1'b0, ir[26:23]} >= NR5)
                    || ({1'b0, ir[22:19]} >= NR5)
                    || (!dec_unary && !dec_muldiv && ({1'b0, ir[18:15]} >= NR5));
    end

    assign muldiv_q = op_q[9] | op_q[10];
    assign unary_q  = op_q[11] | op_q[12];

    // State register
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; fcode_d is the code recorded when entering FAULT
    always_comb begin
        state_d = state_q;
        fcode_d = 2'b00;
        case (state_q)
            S_IDLE: if (start) state_d = S_T0;
            S_T0:   state_d = S_T1;
            S_T1: begin
                // A same-edge mem_ready beats the timeout.
                if (mem_ready) begin
                    state_d = S_T2;
                end else if (MEM_TIMEOUT != 0 && cnt_q == CW'(MEM_TIMEOUT - 1)) begin
                    state_d = S_FAULT;
                    fcode_d = 2'b10;
                end
            end
            S_T2: begin
                if (dec_illegal) begin
                    state_d = S_FAULT;
                    fcode_d = 2'b01;
                end else if (dec_unary) begin
                    state_d = S_T4;
                end else begin
                    state_d = S_T3;
                end
            end
            S_T3: state_d = S_T4;
            S_T4: begin
                if (!muldiv_q || alu_done) begin
                    state_d = S_T5;
                end else if (ALU_TIMEOUT != 0 && cnt_q == CW'(ALU_TIMEOUT - 1)) begin
                    state_d = S_FAULT;
                    fcode_d = 2'b11;
                end
            end
            S_T5:    state_d = muldiv_q ? S_T6 : S_IDLE;
            S_T6:    state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Wait counter, latched instruction fields and fault code
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            cnt_q      <= '0;
            op_q       <= '0;
            ra_q       <= '0;
            rb_q       <= '0;
            rc_q       <= '0;
            fault_code <= 2'b00;
        end else begin
            // Counts consecutive cycles spent waiting in T1/T4; any state change restarts it.
            if (state_d == state_q && (state_q == S_T1 || state_q == S_T4))
                cnt_q <= cnt_q + 16'd1;
            else
                cnt_q <= '0;

            if (state_q == S_T2) begin
                op_q <= dec_op;
                ra_q <= ir[26:23];
                rb_q <= ir[22:19];
                rc_q <= ir[18:15];
            end

            if (state_q == S_IDLE && start)
                fault_code <= 2'b00;
            else if (state_d == S_FAULT && state_q != S_FAULT)
                fault_code <= fcode_d;
        end
    end

    // Moore output decode
    always_comb begin
        PCout    = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        MDRout   = 1'b0;
        PCin     = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Rout     = '0;
        Rin      = '0;
        alu_op   = '0;
        busy     = (state_q != S_IDLE);
        done     = 1'b0;
        fault    = 1'b0;
        case (state_q)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                Rout = muldiv_q ? one_hot(ra_q) : one_hot(rb_q);
                Yin  = 1'b1;
            end
            S_T4: begin
                alu_op = op_q;
                Zin    = 1'b1;
                Rout   = (muldiv_q || unary_q) ? one_hot(rb_q) : one_hot(rc_q);
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (muldiv_q) begin
                    LOin = 1'b1;
                end else begin
                    Rin  = one_hot(ra_q);
                    done = 1'b1;
                end
            end
            S_T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
                done     = 1'b1;
            end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;

  localparam int NR = 8;
  localparam int MT = 15;
  localparam int AT = 40;
  localparam int W  = 17 + 2 + 2*NR + 13;

  // strobe field bit masks, order matches the packing of obs below
  localparam logic [16:0] S_PCOUT = 17'h10000, S_ZLOW  = 17'h08000, S_ZHIGH = 17'h04000;
  localparam logic [16:0] S_MDROUT = 17'h02000, S_PCIN = 17'h01000, S_MARIN = 17'h00800;
  localparam logic [16:0] S_MDRIN = 17'h00400, S_IRIN  = 17'h00200, S_YIN   = 17'h00100;
  localparam logic [16:0] S_ZIN   = 17'h00080, S_HIIN  = 17'h00040, S_LOIN  = 17'h00020;
  localparam logic [16:0] S_INCPC = 17'h00010, S_READ  = 17'h00008, S_BUSY  = 17'h00004;
  localparam logic [16:0] S_DONE  = 17'h00002, S_FLT   = 17'h00001;

  // ---------------- clock / reset / DUT ----------------
  logic Clock = 1'b0;
  logic Clear, start, mem_ready, alu_done;
  logic [31:0] ir;
  logic PCout, Zlowout, Zhighout, MDRout, PCin, MARin, MDRin, IRin;
  logic Yin, Zin, HIin, LOin, IncPC, Read, busy, done, fault;
  logic [NR-1:0] Rout, Rin;
  logic [12:0] alu_op;
  logic [1:0] fault_code;

  always #5 Clock = ~Clock;

  alu_op_sequencer #(.NUM_REGS(NR), .MEM_TIMEOUT(MT), .ALU_TIMEOUT(AT)) dut (
    .Clock(Clock), .Clear(Clear), .start(start), .ir(ir),
    .mem_ready(mem_ready), .alu_done(alu_done),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
    .Rout(Rout), .Rin(Rin), .alu_op(alu_op),
    .busy(busy), .done(done), .fault(fault), .fault_code(fault_code)
  );

  logic [W-1:0] obs;
  assign obs = {PCout, Zlowout, Zhighout, MDRout, PCin, MARin, MDRin, IRin, Yin, Zin,
                HIin, LOin, IncPC, Read, busy, done, fault, fault_code, Rout, Rin, alu_op};

  // ---------------- scoreboard ----------------
  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic mr_q[$];
  logic ad_q[$];
  logic [1:0] exp_fc = 2'b00;

  // opcode of each alu_op bit, ADD = bit 0
  logic [4:0] op_tab [13] = '{5'b00011, 5'b00100, 5'b01001, 5'b01010, 5'b01011, 5'b00111,
                              5'b01000, 5'b00101, 5'b00110, 5'b01111, 5'b10000, 5'b10001,
                              5'b10010};

  task automatic check(input string tag, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] wd(input logic [16:0] s, input logic [1:0] fc,
                                      input logic [NR-1:0] ro, input logic [NR-1:0] ri,
                                      input logic [12:0] op);
    return {s, fc, ro, ri, op};
  endfunction

  function automatic logic [NR-1:0] oh(input int idx);
    logic [NR-1:0] r;
    r = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  function automatic logic rb1();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic [W-1:0] w, input logic mr, input logic ad);
    exp_q.push_back(w);
    mr_q.push_back(mr);
    ad_q.push_back(ad);
  endtask

  // ---------------- reference model ----------------
  // Builds the expected per-cycle output trace of one instruction (cycle 0 = first cycle
  // after the start edge) plus the handshake inputs to drive in each cycle.
  task automatic build_model(input logic [31:0] ir_v, input int w_mem, input int w_alu);
    int opi, ra, rb, rc;
    bit mul, un, bad;
    logic [12:0] aop;
    logic [16:0] t1s;
    exp_q.delete(); mr_q.delete(); ad_q.delete();
    opi = -1;
    for (int i = 0; i < 13; i++) if (op_tab[i] == ir_v[31:27]) opi = i;
    ra = int'(ir_v[26:23]); rb = int'(ir_v[22:19]); rc = int'(ir_v[18:15]);
    mul = (opi == 9 || opi == 10);
    un  = (opi == 11 || opi == 12);
    bad = (opi < 0) || ra >= NR || rb >= NR || (!mul && !un && rc >= NR);
    aop = '0;
    if (opi >= 0) aop[opi] = 1'b1;

    push(wd(S_PCOUT | S_MARIN | S_INCPC | S_ZIN | S_BUSY, '0, '0, '0, '0), rb1(), rb1());
    t1s = S_ZLOW | S_PCIN | S_READ | S_MDRIN | S_BUSY;
    if (MT != 0 && w_mem >= MT) begin
      for (int i = 0; i < MT; i++) push(wd(t1s, '0, '0, '0, '0), 1'b0, rb1());
      push(wd(S_FLT | S_BUSY, 2'b10, '0, '0, '0), rb1(), rb1());
      exp_fc = 2'b10;
      return;
    end
    for (int i = 0; i < w_mem; i++) push(wd(t1s, '0, '0, '0, '0), 1'b0, rb1());
    push(wd(t1s, '0, '0, '0, '0), 1'b1, rb1());
    push(wd(S_MDROUT | S_IRIN | S_BUSY, '0, '0, '0, '0), rb1(), rb1());
    if (bad) begin
      push(wd(S_FLT | S_BUSY, 2'b01, '0, '0, '0), rb1(), rb1());
      exp_fc = 2'b01;
      return;
    end
    if (!un) push(wd(S_YIN | S_BUSY, '0, mul ? oh(ra) : oh(rb), '0, '0), rb1(), rb1());
    if (mul) begin
      if (AT != 0 && w_alu >= AT) begin
        for (int i = 0; i < AT; i++) push(wd(S_ZIN | S_BUSY, '0, oh(rb), '0, aop), rb1(), 1'b0);
        push(wd(S_FLT | S_BUSY, 2'b11, '0, '0, '0), rb1(), rb1());
        exp_fc = 2'b11;
        return;
      end
      for (int i = 0; i < w_alu; i++) push(wd(S_ZIN | S_BUSY, '0, oh(rb), '0, aop), rb1(), 1'b0);
      push(wd(S_ZIN | S_BUSY, '0, oh(rb), '0, aop), rb1(), 1'b1);
      push(wd(S_ZLOW | S_LOIN | S_BUSY, '0, '0, '0, '0), rb1(), rb1());
      push(wd(S_ZHIGH | S_HIIN | S_BUSY | S_DONE, '0, '0, '0, '0), rb1(), rb1());
    end else begin
      push(wd(S_ZIN | S_BUSY, '0, un ? oh(rb) : oh(rc), '0, aop), rb1(), rb1());
      push(wd(S_ZLOW | S_BUSY | S_DONE, '0, '0, oh(ra), '0), rb1(), rb1());
    end
    exp_fc = 2'b00;
  endtask

  // ---------------- driver ----------------
  // Starts one instruction from IDLE and checks every cycle; clear_at >= 0 pulses Clear
  // asynchronously in that cycle instead of finishing the instruction.
  task automatic run(input string name, input logic [31:0] ir_v, input int w_mem,
                     input int w_alu, input int clear_at);
    build_model(ir_v, w_mem, w_alu);
    ir = ir_v;
    start = 1'b1;
    @(posedge Clock); #1;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k == clear_at) begin
        #1 Clear = 1'b1;
        #1 check($sformatf("%s async_clear", name), '0);
        Clear = 1'b0;
        start = 1'b0;
        exp_fc = 2'b00;
        @(posedge Clock); #1;
        check($sformatf("%s post_clear_idle", name), '0);
        return;
      end
      check($sformatf("%s cyc%0d", name, k), exp_q[k]);
      mem_ready = mr_q[k];
      alu_done  = ad_q[k];
      start     = rb1();       // start while busy must be ignored
      @(posedge Clock); #1;
    end
    start = 1'b0;
    check($sformatf("%s idle_after", name), wd('0, exp_fc, '0, '0, '0));
  endtask

  function automatic logic [31:0] mk_ir(input logic [4:0] opc, input int a, input int b,
                                        input int c);
    return {opc, 4'(a), 4'(b), 4'(c), 15'($urandom_range(0, 32767))};
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] rir;
    logic [4:0] opc;
    int wm, wa;
    Clear = 1'b1; start = 1'b0; mem_ready = 1'b0; alu_done = 1'b0; ir = '0;
    #1 check("reset_async", '0);
    repeat (3) @(posedge Clock);
    #1 check("reset_held", '0);
    Clear = 1'b0;
    @(posedge Clock); #1;
    check("idle_after_reset", '0);

    run("add_r1_r2_r3", 32'h18918000, 0, 0, -1);
    run("mul_r4_r5_wait10", 32'h7A280000, 0, 10, -1);
    run("add_memwait3", 32'h18918000, 3, 0, -1);
    run("add_memwait14", 32'h18918000, MT - 1, 0, -1);
    run("mem_timeout", 32'h18918000, 1000, 0, -1);
    run("illegal_op", 32'hF8918000, 0, 0, -1);
    run("illegal_ra15", mk_ir(5'b00011, 15, 1, 2), 0, 0, -1);
    run("illegal_rc9", mk_ir(5'b00100, 1, 2, 9), 0, 0, -1);
    run("neg_ignores_rc", mk_ir(5'b10001, 3, 6, 15), 0, 0, -1);
    run("not_r2_r7", 32'h913C0000, 0, 0, -1);
    run("div_wait39", mk_ir(5'b10000, 6, 7, 0), 2, AT - 1, -1);
    run("alu_timeout", 32'h7A280000, 0, 1000, -1);
    run("mul_clear_in_t4", 32'h7A280000, 0, 20, 8);
    run("add_after_clear", 32'h18918000, 0, 0, -1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) opc = 5'($urandom_range(0, 31));
      else opc = op_tab[$urandom_range(0, 12)];
      rir = mk_ir(opc, $urandom_range(0, 8), $urandom_range(0, 8), $urandom_range(0, 8));
      wm = ($urandom_range(0, 9) == 0) ? $urandom_range(MT - 2, MT + 1) : $urandom_range(0, 3);
      wa = ($urandom_range(0, 9) == 0) ? $urandom_range(AT - 2, AT + 1) : $urandom_range(0, 4);
      run($sformatf("rand%0d", n), rir, wm, wa, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
